// File: rtl/iobuff_sampler_pkg.sv
// Shared edge-select encodings and helpers for the IO buffer input sampler.
package iobuff_sampler_pkg;

    localparam int unsigned EDGE_SEL_W = 2;

    typedef enum logic [EDGE_SEL_W-1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_e;

    // True when a transition to new_level is selected for capture.
    function automatic logic edge_match(input logic [EDGE_SEL_W-1:0] sel, input logic new_level);
        logic hit;
        hit = 1'b0;
        case (edge_sel_e'(sel))
            EDGE_RISE: hit = new_level;
            EDGE_FALL: hit = ~new_level;
            EDGE_BOTH: hit = 1'b1;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/iobuff_evfifo.sv
// Synchronous first-word-fall-through event FIFO with registered full/empty/count.
module iobuff_evfifo #(
    parameter int unsigned W  = 17,
    parameter int unsigned AW = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_nxt;
    logic          full_q;
    logic          empty_q;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    always_comb begin
        do_pop    = pop & ~empty_q;
        do_push   = push & (~full_q | do_pop);
        count_nxt = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_nxt;
            full_q  <= (count_nxt == (AW+1)'(DEPTH));
            empty_q <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/iobuff_sampler.sv
// Pin read-back sampler: synchroniser, glitch filter, edge detect and timestamped event queue.
module iobuff_sampler
    import iobuff_sampler_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_W      = 4,
    parameter int unsigned TS_W        = 16,
    parameter int unsigned FIFO_AW     = 3,
    parameter logic        LEVEL_RST   = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  pin_in,
    input  logic [FILT_W-1:0]     filt_len,
    input  logic [EDGE_SEL_W-1:0] edge_sel,
    output logic                  level,
    output logic                  rise_pulse,
    output logic                  fall_pulse,
    output logic                  ev_valid,
    input  logic                  ev_ready,
    output logic [TS_W:0]         ev_data,
    output logic [FIFO_AW:0]      ev_count,
    output logic                  ev_overflow,
    input  logic                  ov_clr
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   level_q;
    logic [FILT_W-1:0]      cnt_q;
    logic [TS_W-1:0]        ts_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   ov_q;
    logic                   diff_c;
    logic                   upd_c;
    logic                   push_c;
    logic                   pop_c;
    logic                   drop_c;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser runs regardless of en so the filter sees a settled value on re-enable.
    always_ff @(posedge clock) begin
        if (reset) sync_q <= {SYNC_STAGES{LEVEL_RST}};
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
    end

    // cnt >= filt_len is terminal so shrinking filt_len mid-count never stalls the filter.
    always_comb begin
        diff_c = (s != level_q);
        upd_c  = en & diff_c & (cnt_q >= filt_len);
        push_c = upd_c & edge_match(edge_sel, s);
        pop_c  = ev_ready & ~fifo_empty;
        drop_c = push_c & fifo_full & ~pop_c;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= LEVEL_RST;
            cnt_q   <= '0;
            ts_q    <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            rise_q <= upd_c & s;
            fall_q <= upd_c & ~s;
            if (!en || !diff_c) begin
                cnt_q <= '0;
            end else if (upd_c) begin
                level_q <= s;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + FILT_W'(1);
            end
            if (en) ts_q <= ts_q + TS_W'(1);
            if (drop_c)      ov_q <= 1'b1;
            else if (ov_clr) ov_q <= 1'b0;
        end
    end

    iobuff_evfifo #(
        .W  (TS_W + 1),
        .AW (FIFO_AW)
    ) u_evfifo (
        .clock (clock),
        .reset (reset),
        .push  (push_c),
        .pop   (ev_ready),
        .wdata ({s, ts_q}),
        .rdata (ev_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (ev_count)
    );

    assign level       = level_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign ev_valid    = ~fifo_empty;
    assign ev_overflow = ov_q;

endmodule

// File: tb/tb_iobuff_sampler.sv
// Scoreboard bench for iobuff_sampler: directed scenarios followed by randomized traffic.
module tb_iobuff_sampler;

    localparam int SS    = 2;
    localparam int FW    = 4;
    localparam int TW    = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          en;
    logic          pin_in;
    logic [FW-1:0] filt_len;
    logic [1:0]    edge_sel;
    logic          level;
    logic          rise_pulse;
    logic          fall_pulse;
    logic          ev_valid;
    logic          ev_ready;
    logic [TW:0]   ev_data;
    logic [AW:0]   ev_count;
    logic          ev_overflow;
    logic          ov_clr;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    iobuff_sampler #(
        .SYNC_STAGES (SS),
        .FILT_W      (FW),
        .TS_W        (TW),
        .FIFO_AW     (AW),
        .LEVEL_RST   (1'b1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .pin_in      (pin_in),
        .filt_len    (filt_len),
        .edge_sel    (edge_sel),
        .level       (level),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_data     (ev_data),
        .ev_count    (ev_count),
        .ev_overflow (ev_overflow),
        .ov_clr      (ov_clr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pin history delayed by the synchroniser depth, a run length of
    // disagreeing enabled cycles, an enabled-cycle timestamp and an event queue.
    bit          m_pinq[$];
    int          m_run;
    bit          m_level;
    int          m_ts;
    int          m_occ;
    bit          m_ov;
    bit          m_rise;
    bit          m_fall;
    logic [TW:0] sb[$];

    always @(posedge clock) begin
        bit s;
        bit upd;
        bit push;
        bit pop;
        bit take;
        logic [TW-1:0] ts_v;
        if (reset) begin
            m_pinq = {};
            for (int i = 0; i < SS; i++) m_pinq.push_back(1'b1);
            m_level = 1'b1;
            m_run   = 0;
            m_ts    = 0;
            m_occ   = 0;
            m_ov    = 1'b0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
            sb.delete();
        end else begin
            s = m_pinq.pop_front();
            m_pinq.push_back(pin_in);
            upd = 1'b0;
            if (!en || s == m_level) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run >= int'(filt_len) + 1) begin
                    upd   = 1'b1;
                    m_run = 0;
                end
            end
            m_rise = upd && s;
            m_fall = upd && !s;
            push = upd && ((s && edge_sel[0]) || (!s && edge_sel[1]));
            pop  = ev_ready && (m_occ > 0);
            take = push && ((m_occ < DEPTH) || pop);
            ts_v = TW'(m_ts);
            if (take) sb.push_back({s, ts_v});
            if (push && !take) m_ov = 1'b1;
            else if (ov_clr)   m_ov = 1'b0;
            m_occ = m_occ + (take ? 1 : 0) - (pop ? 1 : 0);
            if (upd) m_level = s;
            if (en)  m_ts = (m_ts + 1) % (1 << TW);
        end
    end

    // Monitor: every handshake must deliver the oldest expected event.
    always @(posedge clock) begin
        logic [TW:0] exp_d;
        if (!reset && chk_on && ev_valid && ev_ready) begin
            if (sb.size() == 0) begin
                chk("ev_unexpected", 1, 0);
            end else begin
                exp_d = sb.pop_front();
                chk("ev_data", int'(ev_data), int'(exp_d));
            end
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            chk("level", level, m_level);
            chk("rise_pulse", rise_pulse, m_rise);
            chk("fall_pulse", fall_pulse, m_fall);
            chk("ev_count", int'(ev_count), m_occ);
            chk("ev_valid", ev_valid, (m_occ > 0) ? 1 : 0);
            chk("ev_overflow", ev_overflow, m_ov);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        pin_in   = 1'b1;
        ev_ready = 1'b0;
        ov_clr   = 1'b0;
        filt_len = '0;
        edge_sel = 2'b11;
        tick(2);
        chk_on = 1'b1;
        tick(1);
        chk("rst_level", level, 1);
        chk("rst_count", int'(ev_count), 0);
        reset    = 1'b0;
        en       = 1'b1;
        ev_ready = 1'b1;
        tick(10);

        // filt_len = 0: fall pulse three cycles after the pin change
        pin_in = 1'b0;
        tick(1); chk("lat_fall_c1", fall_pulse, 0);
        tick(1); chk("lat_fall_c2", fall_pulse, 0);
        tick(1); chk("lat_fall_c3", fall_pulse, 1);
        tick(5);
        pin_in = 1'b1;
        tick(8);

        // filt_len = 3: a 3-cycle glitch is rejected, a 4-cycle one passes
        filt_len = 4'd3;
        pin_in = 1'b0; tick(3); pin_in = 1'b1; tick(12);
        chk("glitch3_level", level, 1);
        pin_in = 1'b0; tick(4); pin_in = 1'b1; tick(12);

        // fill the FIFO past capacity, clear overflow, then push+pop while full
        filt_len = '0;
        ev_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pin_in = ~pin_in;
            tick(4);
        end
        chk("full_count", int'(ev_count), DEPTH);
        chk("full_overflow", ev_overflow, 1);
        ov_clr = 1'b1; tick(1); ov_clr = 1'b0;
        chk("ov_cleared", ev_overflow, 0);
        pin_in = ~pin_in;
        tick(2);
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
        chk("full_pushpop_count", int'(ev_count), DEPTH);
        tick(3);
        ev_ready = 1'b1;
        tick(12);

        // rise-only capture
        edge_sel = 2'b01;
        for (int i = 0; i < 4; i++) begin
            pin_in = ~pin_in;
            tick(6);
        end
        edge_sel = 2'b11;

        // disabled: pin wiggles are ignored, re-enable restarts the count
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pin_in = 1'($urandom_range(0, 1));
            tick(1);
        end
        pin_in = ~level;
        tick(3);
        filt_len = 4'd2;
        en = 1'b1;
        tick(10);

        // mid-run reset with queued events
        filt_len = '0;
        ev_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pin_in = ~pin_in;
            tick(4);
        end
        reset = 1'b1; tick(2); reset = 1'b0;
        ev_ready = 1'b1;
        pin_in = 1'b1;
        tick(6);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) pin_in = ~pin_in;
            en       = ($urandom_range(0, 15) != 0);
            ev_ready = ($urandom_range(0, 2) == 0);
            ov_clr   = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 63) == 0) filt_len = FW'($urandom_range(0, 4));
            if ($urandom_range(0, 63) == 0) edge_sel = 2'($urandom_range(0, 3));
            tick(1);
        end

        // drain
        ov_clr   = 1'b0;
        edge_sel = 2'b00;
        ev_ready = 1'b1;
        tick(20);
        chk("sb_drained", sb.size(), 0);
        chk("fifo_drained", int'(ev_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
